// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source level/edge capture, mask, SW set/clear, priority vector.
// Optional `IRQ_AGG_SYNC_EN adds a two-flop input synchronizer ahead of capture.
module irq_aggregator #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq
);

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_SW_SET   = 3'd5;

  logic [N_IRQ-1:0] irq_s;

`ifdef IRQ_AGG_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync1_d;
  logic [N_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [15:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] sw_set;
  logic [N_IRQ-1:0] active;
  logic [3:0]       vec_idx;

  assign wr_en    = chipselect & ~write_n;
  assign edge_det = irq_s & ~irq_prev_q;
  assign w1c      = (wr_en && address == ADDR_PENDING) ? writedata[N_IRQ-1:0] : '0;
  assign sw_set   = (wr_en && address == ADDR_SW_SET)  ? writedata[N_IRQ-1:0] : '0;
  assign active   = pending_q & mask_q;

  // Scan downwards so the lowest active index wins.
  always_comb begin
    vec_idx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 4'(i);
    end
  end

  // Set (edge or SW_SET) has priority over W1C; level bits track the input.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_sel_q[i]) begin
        if (edge_det[i] || sw_set[i]) pending_d[i] = 1'b1;
        else if (w1c[i])              pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = irq_s[i];
      end
    end
  end

  always_comb begin
    irq_prev_d = irq_s;
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    if (wr_en && address == ADDR_MASK)     mask_d     = writedata[N_IRQ-1:0];
    if (wr_en && address == ADDR_EDGE_SEL) edge_sel_d = writedata[N_IRQ-1:0];
    irq_d = |active;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING:  readdata_d[N_IRQ-1:0] = pending_q;
      ADDR_MASK:     readdata_d[N_IRQ-1:0] = mask_q;
      ADDR_EDGE_SEL: readdata_d[N_IRQ-1:0] = edge_sel_q;
      ADDR_ACTIVE:   readdata_d[N_IRQ-1:0] = active;
      ADDR_VECTOR: begin
        readdata_d[15]  = |active;
        readdata_d[3:0] = vec_idx;
      end
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: per-cycle vector table plus a read scoreboard.
module tb_irq_aggregator;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  irq_aggregator #(.N_IRQ(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  irq_in;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rd_go = 1'b0;
  logic rd_chk = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic wr, input logic [2:0] a, input logic [15:0] d,
                     input logic [7:0] ii, input logic [15:0] er, input logic ei);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.wdata = d; v.irq_in = ii; v.exp_rd = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic push_rd(input string n, input logic [15:0] e);
    sb_t s;
    s.name = n; s.exp = e;
    sb_q.push_back(s);
  endtask

  // Read issued at a negedge is sampled on the next posedge, result checked at the following negedge.
  always @(posedge clk) rd_chk <= rd_go;

  always @(negedge clk) begin
    if (rd_chk) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 16'h0001, 16'h0000);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        chk(s.name, readdata, s.exp);
      end
    end
  end

  initial begin
    // Reset state
    add("rst_pending", 0, 3'd0, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_mask",    0, 3'd1, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_edgesel", 0, 3'd2, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_active",  0, 3'd3, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_vector",  0, 3'd4, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_swset",   0, 3'd5, 16'h0, 8'h00, 16'h0000, 0);
    add("rst_rsv7",    0, 3'd7, 16'h0, 8'h00, 16'h0000, 0);
    // Level source 0
    add("lvl_wr_mask", 1, 3'd1, 16'h0001, 8'h00, 16'h0, 0);
    add("lvl_rd_mask", 0, 3'd1, 16'h0,    8'h00, 16'h0001, 0);
    add("lvl_hi1",     0, 3'd0, 16'h0,    8'h01, 16'h0000, 0);
    add("lvl_hi2",     0, 3'd0, 16'h0,    8'h01, 16'h0001, 1);
    add("lvl_w1c",     1, 3'd0, 16'h0001, 8'h01, 16'h0,    1);
    add("lvl_hi4",     0, 3'd0, 16'h0,    8'h01, 16'h0001, 1);
    add("lvl_hi5_act", 0, 3'd3, 16'h0,    8'h01, 16'h0001, 1);
    add("lvl_lo1_vec", 0, 3'd4, 16'h0,    8'h00, 16'h8000, 1);
    add("lvl_lo2",     0, 3'd0, 16'h0,    8'h00, 16'h0000, 0);
    // Edge source 2
    add("edg_wr_sel",  1, 3'd2, 16'h0004, 8'h00, 16'h0, 0);
    add("edg_wr_mask", 1, 3'd1, 16'h0004, 8'h00, 16'h0, 0);
    add("edg_pulse",   0, 3'd2, 16'h0,    8'h04, 16'h0004, 0);
    add("edg_pend",    0, 3'd0, 16'h0,    8'h00, 16'h0004, 1);
    add("edg_vec",     0, 3'd4, 16'h0,    8'h00, 16'h8002, 1);
    add("edg_w1c",     1, 3'd0, 16'h0004, 8'h00, 16'h0,    1);
    add("edg_cleared", 0, 3'd0, 16'h0,    8'h00, 16'h0000, 0);
    // Simultaneous edge and W1C: set wins
    add("sim_set_clr", 1, 3'd0, 16'h0004, 8'h04, 16'h0,    0);
    add("sim_pend",    0, 3'd0, 16'h0,    8'h00, 16'h0004, 1);
    add("sim_w1c",     1, 3'd0, 16'h0004, 8'h00, 16'h0,    1);
    add("sim_cleared", 0, 3'd0, 16'h0,    8'h00, 16'h0000, 0);
    // Priority among sources 1, 3, 5
    add("pri_wr_sel",  1, 3'd2, 16'h00AE, 8'h00, 16'h0, 0);
    add("pri_pulse",   0, 3'd2, 16'h0,    8'h2A, 16'h00AE, 0);
    add("pri_mask_ff", 1, 3'd1, 16'h00FF, 8'h00, 16'h0, 0);
    add("pri_vec1",    0, 3'd4, 16'h0,    8'h00, 16'h8001, 1);
    add("pri_mask_fd", 1, 3'd1, 16'h00FD, 8'h00, 16'h0, 1);
    add("pri_vec3",    0, 3'd4, 16'h0,    8'h00, 16'h8003, 1);
    add("pri_active",  0, 3'd3, 16'h0,    8'h00, 16'h0028, 1);
    add("pri_swset",   1, 3'd5, 16'h0080, 8'h00, 16'h0, 1);
    add("pri_pend",    0, 3'd0, 16'h0,    8'h00, 16'h00AA, 1);
    add("pri_rd_swset",0, 3'd5, 16'h0,    8'h00, 16'h0000, 1);
    add("msk_off",     1, 3'd1, 16'h0000, 8'h00, 16'h0, 1);
    add("msk_off_act", 0, 3'd3, 16'h0,    8'h00, 16'h0000, 0);
    add("msk_on",      1, 3'd1, 16'h00FF, 8'h00, 16'h0, 0);
    add("rsv6_rd",     0, 3'd6, 16'h0,    8'h00, 16'h0000, 1);
    add("rsv6_wr",     1, 3'd6, 16'hFFFF, 8'h00, 16'h0,    1);
    add("rsv7_rd",     0, 3'd7, 16'h0,    8'h00, 16'h0000, 1);

    reset_n = 1'b0; irq_in = '0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_irq_pin", {15'd0, irq}, 16'h0000);
    chk("rst_rd_pin", readdata, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      chipselect = 1'b1;
      address    = vecs[i].addr;
      write_n    = ~vecs[i].wr;
      writedata  = vecs[i].wdata;
      irq_in     = vecs[i].irq_in;
      rd_go      = ~vecs[i].wr;
      if (!vecs[i].wr) push_rd(vecs[i].name, vecs[i].exp_rd);
      @(negedge clk);
      chk({vecs[i].name, "_irq"}, {15'd0, irq}, {15'd0, vecs[i].exp_irq});
    end

    // Reset asserted mid-operation while irq is high
    rd_go = 1'b0; chipselect = 1'b0; write_n = 1'b1; irq_in = '0; address = 3'd0;
    @(posedge clk); #2;
    chk("pre_rst_irq", {15'd0, irq}, 16'h0001);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_irq", {15'd0, irq}, 16'h0000);
    chk("mid_rst_rd", readdata, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      address = 3'(a);
      rd_go   = 1'b1;
      push_rd($sformatf("post_rst_rd%0d", a), 16'h0000);
      @(negedge clk);
      chk($sformatf("post_rst_irq%0d", a), {15'd0, irq}, 16'h0000);
    end
    rd_go = 1'b0;
    @(negedge clk);
    chk("post_rst_irq_final", {15'd0, irq}, 16'h0000);
    chk("sb_drained", 16'(sb_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Memory-mapped interrupt aggregator that consumes the level `irq` outputs of the Nios_CPU_qsys peripherals, including the high-resolution timer, and presents one registered interrupt to the CPU. Each source has its own capture mode (level or rising edge), a mask bit, software set and clear, and an index into a fixed-priority vector register. It is an Avalon-MM slave with a 16-bit data path, one-cycle registered read latency, and no wait states.

## Interface
- `N_IRQ`, default 8: number of sources, legal range 1..15; unused register bits read 0.
- `clk` input, 1 bit: single clock for all logic.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `address` input, 3 bits: register select.
- `chipselect` input, 1 bit: slave select.
- `write_n` input, 1 bit: active-low write strobe; write occurs when `chipselect && ~write_n`.
- `writedata` input, 16 bits: write data.
- `readdata` output, 16 bits: registered read data.
- `irq_in` input, `N_IRQ` bits: source interrupts, active high.
- `irq` output, 1 bit: registered aggregate interrupt to the CPU.

## Operation
- Registers (address: name, access):
  - 0: PENDING, RW1C. A write of 1 clears edge-mode bits; level-mode bits ignore writes.
  - 1: MASK, RW. 1 = enabled.
  - 2: EDGE_SEL, RW. 1 = rising-edge capture, 0 = level.
  - 3: ACTIVE, RO. PENDING & MASK.
  - 4: VECTOR, RO. Bit 15 = any ACTIVE bit set; bits 3:0 = lowest-index ACTIVE source, 0 when none.
  - 5: SW_SET, WO, reads 0. A write of 1 sets the PENDING bit of edge-mode sources; level-mode bits ignore writes.
  - 6, 7: reserved, read 0, writes ignored.
- Edge detection uses `irq_prev`, the input registered every cycle. An edge is `irq_in & ~irq_prev`.
- Pending update per bit, each clock:
  - Level mode: pending <= `irq_in`.
  - Edge mode: if edge or SW_SET-1, pending <= 1; else if PENDING W1C-1, pending <= 0; else hold.
- Set beats clear. An edge in the same cycle as a W1C of that bit leaves the bit 1.
- Mode switch:
  - Edge to level: the bit follows the input from the next clock.
  - Level to edge: the bit holds its current value until cleared.
- `irq` <= |ACTIVE, registered. Masking a pending bit drops `irq` one clock after the MASK write.
- `readdata` <= the read mux selected by `address`, every clock, regardless of `chipselect`.
- Reset values: PENDING 0, MASK 0, EDGE_SEL 0, `irq_prev` 0, `readdata` 0, `irq` 0.
- A source already high at reset release counts as an edge on the first clock.

## Timing
- Input path, with the input first sampled high at clock edge k:
  - The PENDING bit is 1 after edge k.
  - `irq` is high after edge k+1, provided the source is masked in.
- Register writes take effect at the clock edge on which the write is sampled.
- `irq` reflects a write one edge later.
- Read: `readdata` is valid after the edge that samples `address`, which is a one-cycle latency.
- A read issued in the cycle after a write returns the new value.
- Asserting reset mid-operation clears all state immediately. No pending edge survives reset.

## Configuration
- `IRQ_AGG_SYNC_EN` defined:
  - `irq_in` passes through a two-flop synchronizer before edge detection and level capture, for sources outside the `clk` domain.
  - All input-path latencies grow by 2 clocks.
  - Synchronizer flops reset to 0.
- `IRQ_AGG_SYNC_EN` undefined: `irq_in` is used directly, and the latencies are as listed under Timing.

## Test plan
- Reset release with `irq_in`=0: all registers read 0, `irq`=0.
- Level source:
  - Stimulus: MASK=0x01, EDGE_SEL=0, `irq_in[0]` high for 5 clocks then low.
  - Response: PENDING[0] follows the input delayed 1 clock; `irq` follows the input delayed 2 clocks.
  - A W1C write of 0x01 during the high period has no effect.
- Edge source:
  - Stimulus: EDGE_SEL=0x04, MASK=0x04, a 1-clock pulse on `irq_in[2]`.
  - Response: PENDING=0x0004 latched and VECTOR=0x8002.
  - A W1C write of 0x0004 clears PENDING, and `irq` drops 1 clock later.
- Simultaneous set and clear: an edge on source 2 in the same cycle as a W1C of 0x0004 leaves PENDING[2]=1.
- Priority:
  - Stimulus: sources 1, 3 and 5 pending with MASK=0xFF.
  - Response: VECTOR=0x8001; after MASK=0xFD, VECTOR=0x8003.
  - SW_SET of 0x0080 with EDGE_SEL[7]=1 sets PENDING[7].
- Reset mid-operation: assert `reset_n` with `irq`=1. `irq` and PENDING go to 0 immediately and stay 0 after release while inputs are low.
